fpu_mul_seq: RTL and testbench
==============================

# fpu_mul_seq

Multi-cycle IEEE-754 single-precision multiplier with valid/ready handshakes on both sides. It is the sequential, handshaked counterpart of the combinational `FloatingPointMul`. It accepts an operand pair from an upstream initiator, such as a vector driver or the core execute stage, and returns a product plus exception flags to a downstream consumer. It uses a shift-add mantissa datapath so that no 24x24 combinational multiplier is needed, and it holds its result until the consumer takes it.

## Interface
- `RADIX_BITS`, default 1: multiplier bits retired per MUL cycle. Driven only by the `FPU_MUL_RADIX4_EN` macro; not set directly.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: operand pair valid.
- `in_ready` out, 1: block can accept an operand pair.
- `a` in, 32: operand A, IEEE-754 binary32.
- `b` in, 32: operand B, IEEE-754 binary32.
- `out_valid` out, 1: result valid.
- `out_ready` in, 1: consumer accepts the result.
- `y` out, 32: product, binary32.
- `flags` out, 4: {invalid, overflow, underflow, inexact}.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: shift-add over mantissas with hidden bit.
  - NORM: normalize.
  - ROUND: round and pack.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→MUL on `in_valid && in_ready`. `a` and `b` are captured on that edge.
  - MUL→NORM when the bit counter reaches 24/RADIX_BITS iterations.
  - NORM→ROUND, then ROUND→DONE, unconditionally.
  - DONE→IDLE on `out_ready`.
- Unpack:
  - sign = a[31]^b[31].
  - Raw exponent sum is computed in 10-bit signed arithmetic: ea+eb-127.
  - Subnormal inputs (exp=0, mantissa≠0) are flushed to signed zero. Flushing does not raise a flag.
- MUL:
  - 48-bit product register.
  - Each iteration conditionally adds the 24-bit multiplicand, shifted to the current position. The counter is 5 bits.
- NORM:
  - If product[47]=1: shift right 1 and increment the exponent.
  - Otherwise the leading one is at bit 46.
  - Keep 24 significant bits plus guard and round bits. Sticky is the OR of all remaining bits.
- ROUND:
  - Round to nearest, ties to even.
  - A mantissa carry-out increments the exponent.
  - Final exponent ≥255: y = signed infinity; overflow=1, inexact=1.
  - Final exponent ≤0: y = signed zero; underflow=1, inexact=1.
  - inexact = guard|round|sticky.
- Special cases are detected at capture and override the packed result in ROUND. Latency is unchanged.
  - Any NaN input, or inf×0: y=0x7FC00000. invalid=1 only for signalling NaN or inf×0.
  - inf×finite-nonzero: signed infinity, no flags.
  - zero×finite: signed zero, no flags.
- `y` and `flags` hold stable throughout DONE.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release. `out_valid`=0, `y`=0, `flags`=0, state=IDLE.
- Latency from accepting edge to `out_valid` rising:
  - 26 cycles by default: 24 MUL + NORM + ROUND.
  - 14 cycles with the macro: 12 MUL + NORM + ROUND.
  - The same latency applies to all operand classes.
- `in_ready` is high only in IDLE. The block holds one operation at a time, so throughput is at most one result per latency+2 cycles.
- In DONE with `out_ready`=1: `out_valid` drops on that edge and `in_ready` is high in the next cycle. There is no same-cycle accept-and-return.
- `out_ready` held low: the block stays in DONE indefinitely, `y` and `flags` stay unchanged, and `in_ready`=0.
- `in_valid` outside IDLE is ignored. Operands do not need to be held after the accepting edge.
- `rst_n` asserted mid-operation: all state clears immediately and the in-flight operation is discarded. No `out_valid` is produced for it.

## Configuration
- `FPU_MUL_RADIX4_EN`:
  - Defined: RADIX_BITS=2. Each MUL cycle adds 0, 1×, 2× or 3× the multiplicand, using a 26-bit precomputed 3× term. MUL takes 12 cycles; latency is 14.
  - Undefined: RADIX_BITS=1, 24 MUL cycles, latency 26.
  - Results and flags are bit-identical in both builds.

## Test plan
- 0x3FC00000×0x40000000 (1.5×2.0) → y=0x40400000, flags=0. `out_valid` rises exactly 26 cycles (14 with macro) after accept.
- 0x7F800000×0x00000000 → y=0x7FC00000, flags=4'b1000. 0xFF800000×0x40000000 → y=0xFF800000, flags=0.
- 0x7F7FFFFF×0x40000000 → y=0x7F800000, flags=4'b0101. 0x00800000×0x00800000 → y=0x00000000, flags=4'b0011.
- 0x3F800001×0x3F800001 → y=0x3F800002, inexact=1. 0x80000000×0x3F800000 → y=0x80000000.
- Hold `out_ready`=0 for 50 cycles in DONE → `y` is stable, `in_ready`=0, and `in_valid` pulses are ignored. Release → one `out_valid` handshake, then `in_ready`=1 on the next cycle.
- Assert `rst_n`=0 at MUL cycle 10 → outputs read their reset values immediately. After release, a new pair (0x40400000×0x40400000) returns 0x41100000.

Source files
------------

// File: rtl/fpu_mul_seq.sv
// Multi-cycle IEEE-754 binary32 multiplier, shift-add datapath, valid/ready on both sides.
// Build option: define FPU_MUL_RADIX4_EN to retire two multiplier bits per MUL cycle.
module fpu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [3:0]  flags
);

`ifdef FPU_MUL_RADIX4_EN
  localparam int unsigned RADIX_BITS = 2;
`else
  localparam int unsigned RADIX_BITS = 1;
`endif
  localparam int unsigned SW   = 24 + RADIX_BITS;
  localparam logic [4:0]  LAST = 5'(24 / RADIX_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  logic [2:0]        r_state;
  logic [4:0]        r_cnt;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [23:0]       r_mcand;
  logic [47:0]       r_prod;
  logic [1:0]        r_sp;
  logic              r_inv;
  logic [23:0]       r_mant;
  logic              r_g, r_r, r_s;
  logic [31:0]       r_y;
  logic [3:0]        r_flags;
`ifdef FPU_MUL_RADIX4_EN
  logic [25:0]       r_m3;
`endif

  logic [7:0]  w_ea, w_eb;
  logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic        w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [1:0]  w_sp;
  logic        w_inv;
  logic [SW-1:0] w_addend, w_sum;
  logic [47:0] w_prod_next;
  logic        w_up;
  logic [24:0] w_rsum;
  logic signed [9:0] w_efin;
  logic [22:0] w_frac;

  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_a_nan  = (&w_ea) && (|a[22:0]);
  assign w_b_nan  = (&w_eb) && (|b[22:0]);
  assign w_a_snan = w_a_nan && !a[22];
  assign w_b_snan = w_b_nan && !b[22];
  assign w_a_inf  = (&w_ea) && !(|a[22:0]);
  assign w_b_inf  = (&w_eb) && !(|b[22:0]);
  // exp==0 covers both true zero and flushed subnormals
  assign w_a_zero = !(|w_ea);
  assign w_b_zero = !(|w_eb);

  always_comb begin
    w_sp  = SP_NONE;
    w_inv = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_sp  = SP_NAN;
      w_inv = w_a_snan || w_b_snan;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_sp  = SP_NAN;
      w_inv = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_sp = SP_INF;
    end else if (w_a_zero || w_b_zero) begin
      w_sp = SP_ZERO;
    end
  end

  // Multiplier sits in the low half of r_prod and shifts out as partial sums shift in
  always_comb begin
`ifdef FPU_MUL_RADIX4_EN
    case (r_prod[1:0])
      2'd0:    w_addend = '0;
      2'd1:    w_addend = {2'b00, r_mcand};
      2'd2:    w_addend = {1'b0, r_mcand, 1'b0};
      default: w_addend = r_m3;
    endcase
`else
    w_addend = r_prod[0] ? {1'b0, r_mcand} : '0;
`endif
  end

  assign w_sum       = {{RADIX_BITS{1'b0}}, r_prod[47:24]} + w_addend;
  assign w_prod_next = {w_sum, r_prod[23:RADIX_BITS]};

  assign w_up   = r_g && (r_r || r_s || r_mant[0]);
  assign w_rsum = {1'b0, r_mant} + {24'd0, w_up};
  assign w_efin = r_exp + $signed({9'd0, w_rsum[24]});
  assign w_frac = w_rsum[24] ? w_rsum[23:1] : w_rsum[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_sp    <= SP_NONE;
      r_inv   <= 1'b0;
      r_mant  <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
      r_y     <= '0;
      r_flags <= '0;
`ifdef FPU_MUL_RADIX4_EN
      r_m3    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sign  <= a[31] ^ b[31];
          r_exp   <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
          r_mcand <= {1'b1, a[22:0]};
          r_prod  <= {24'd0, 1'b1, b[22:0]};
          r_sp    <= w_sp;
          r_inv   <= w_inv;
          r_cnt   <= '0;
`ifdef FPU_MUL_RADIX4_EN
          r_m3    <= {2'b00, 1'b1, a[22:0]} + {1'b0, 1'b1, a[22:0], 1'b0};
`endif
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == LAST) r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_prod[47]) begin
            r_mant <= r_prod[47:24];
            r_g    <= r_prod[23];
            r_r    <= r_prod[22];
            r_s    <= |r_prod[21:0];
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_mant <= r_prod[46:23];
            r_g    <= r_prod[22];
            r_r    <= r_prod[21];
            r_s    <= |r_prod[20:0];
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          case (r_sp)
            SP_NAN: begin
              r_y     <= 32'h7FC0_0000;
              r_flags <= {r_inv, 3'b000};
            end
            SP_INF: begin
              r_y     <= {r_sign, 8'hFF, 23'd0};
              r_flags <= 4'b0000;
            end
            SP_ZERO: begin
              r_y     <= {r_sign, 31'd0};
              r_flags <= 4'b0000;
            end
            default: begin
              if (w_efin >= 10'sd255) begin
                r_y     <= {r_sign, 8'hFF, 23'd0};
                r_flags <= 4'b0101;
              end else if (w_efin <= 10'sd0) begin
                r_y     <= {r_sign, 31'd0};
                r_flags <= 4'b0011;
              end else begin
                r_y     <= {r_sign, w_efin[7:0], w_frac};
                r_flags <= {3'b000, r_g | r_r | r_s};
              end
            end
          endcase
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // rst_n gating keeps in_ready low while reset is held even though the state reads IDLE
  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed self-checking bench for fpu_mul_seq (default and FPU_MUL_RADIX4_EN builds).
module tb_fpu_mul_seq;

`ifdef FPU_MUL_RADIX4_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 26;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  fpu_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation, checks latency and result; hold>0 keeps out_ready low that many cycles
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ey, input logic [3:0] ef, input int hold);
    int cyc;
    logic [31:0] y0;
    logic [3:0]  f0;
    @(negedge clk);
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(LAT));
    check({tag, " y"}, y, ey);
    check({tag, " flags"}, 32'(flags), 32'(ef));
    if (hold > 0) begin
      y0 = y; f0 = flags;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = (i % 7 == 3);
        a = 32'h4000_0000 + 32'(i); b = 32'h3F80_0000;
        if (i % 10 == 9) begin
          check({tag, " hold_y"}, y, y0);
          check({tag, " hold_flags"}, 32'(flags), 32'(f0));
          check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
          check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        end
      end
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst y", y, 32'd0);
    check("rst flags", 32'(flags), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel in_ready", 32'(in_ready), 32'd1);

    run_op("1.5x2",      32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 0);
    run_op("inf_x_0",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0);
    run_op("ninf_x_2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 0);
    run_op("overflow",   32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0101, 0);
    run_op("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 0);
    run_op("inexact",    32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 0);
    run_op("neg_zero",   32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000, 0);
    run_op("tie_even",   32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, 0);
    run_op("max_mant",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0001, 0);
    run_op("snan",       32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 0);
    run_op("qnan",       32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0000, 0);
    run_op("subn_flush", 32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 4'b0000, 0);
    run_op("hold",       32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 50);

    // Mid-operation reset: start a product, abort it ten MUL cycles in
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3FC0_0000; b = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst y", y, 32'd0);
    check("midrst flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst rel in_ready", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < LAT + 4; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("midrst no_valid", 32'(seen), 32'd0);
    end
    run_op("3x3", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
